// File: rtl/plugin_dispatch.sv
// plugin_dispatch: issue/writeback stage between the RS5 execute stage and a start/busy/done plugin.
// Define PLUGIN_DISPATCH_PERF_EN to build the perf_ops / perf_timeouts counters.
module plugin_dispatch #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [4:0]      req_rd,
    input  logic            flush,
    output logic            stall,
    output logic            plugin_start,
    output logic [XLEN-1:0] plugin_operand_a,
    output logic [XLEN-1:0] plugin_operand_b,
    input  logic [XLEN-1:0] plugin_result,
    input  logic            plugin_busy,
    input  logic            plugin_done,
    output logic            wb_valid,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_error,
    output logic [31:0]     perf_ops,
    output logic [31:0]     perf_timeouts
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITEBACK,
        DRAIN
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] result_q;
    logic [4:0]      rd_q;
    logic            error_q;
    logic [CW-1:0]   count;
    logic            timed_out;
    logic            accept;
    logic            unused_busy;

    // Busy is observed only for debug; progress relies on done or the timeout.
    assign unused_busy = plugin_busy;

    assign timed_out = (count == TMAX);
    assign accept    = (state == IDLE) && req_valid && !flush;

    always_comb begin
        next_state   = state;
        req_ready    = 1'b0;
        plugin_start = 1'b0;
        wb_valid     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) next_state = ISSUE;
            end
            ISSUE: begin
                plugin_start = 1'b1;
                next_state   = flush ? DRAIN : WAIT;
            end
            WAIT: begin
                if (plugin_done)    next_state = flush ? DRAIN : WRITEBACK;
                else if (flush)     next_state = DRAIN;
                else if (timed_out) next_state = WRITEBACK;
            end
            WRITEBACK: begin
                wb_valid   = 1'b1;
                next_state = IDLE;
            end
            DRAIN: begin
                if (plugin_done || timed_out) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // The plugin cannot be aborted, so the counter keeps running through DRAIN too.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            rd_q     <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
            count    <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a    <= req_rs1;
                        op_b    <= req_rs2;
                        rd_q    <= req_rd;
                        error_q <= 1'b0;
                    end
                end
                ISSUE: count <= '0;
                WAIT: begin
                    if (!timed_out) count <= count + CW'(1);
                    if (plugin_done) begin
                        result_q <= plugin_result;
                        error_q  <= 1'b0;
                    end else if (!flush && timed_out) begin
                        error_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (!timed_out) count <= count + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign stall            = (state != IDLE) || req_valid;
    assign plugin_operand_a = op_a;
    assign plugin_operand_b = op_b;
    assign wb_rd            = wb_valid ? rd_q : 5'd0;
    assign wb_data          = (wb_valid && !error_q) ? result_q : '0;
    assign wb_error         = wb_valid && error_q;
    assign wb_we            = wb_valid && !error_q && (rd_q != 5'd0);

`ifdef PLUGIN_DISPATCH_PERF_EN
    logic [31:0] ops_q;
    logic [31:0] timeouts_q;
    logic        timeout_event;

    assign timeout_event = !plugin_done && timed_out &&
                           (((state == WAIT) && !flush) || (state == DRAIN));

    always_ff @(posedge clk) begin
        if (reset) begin
            ops_q      <= '0;
            timeouts_q <= '0;
        end else begin
            if ((state == WRITEBACK) && !error_q) ops_q <= ops_q + 32'd1;
            if (timeout_event) timeouts_q <= timeouts_q + 32'd1;
        end
    end

    assign perf_ops      = ops_q;
    assign perf_timeouts = timeouts_q;
`else
    assign perf_ops      = 32'd0;
    assign perf_timeouts = 32'd0;
`endif

endmodule
